// File: rtl/sbox_lookup_seq_if.sv
// Stream handshake bundle for sbox_lookup_seq: 48-bit input stream, 32-bit output stream.
// slave is the engine side, master the upstream/downstream side.
interface sbox_lookup_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sbox_lookup_seq.sv
// Time-multiplexed DES S-box engine: eight lookups through one shared 512x4 registered ROM.
// Optional macro SBOX_SEQ_OVERLAP_EN lets a new input be accepted on the output handshake edge.
module sbox_lookup_seq (
  input  logic               clk,
  input  logic               rst_n,
  sbox_lookup_seq_if.slave   bus,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StLookup, StDrain, StDone} state_e;

  // One 256-bit row per S-box, entries row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] SboxRom [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [47:0]     data_q, data_d;
  logic [7:0][3:0] out_q, out_d;
  logic [3:0]      rom_q;

  logic [7:0][5:0] in_chunks;
  logic [5:0]      chunk;
  logic [8:0]      rom_addr;
  logic [2:0]      wr_box;
  logic            accept;

  // Box 0 (S1) lives in the top chunk/nibble, so packed element index is ~box.
  assign in_chunks = data_q;
  assign chunk     = in_chunks[~cnt_q];
  assign rom_addr  = {cnt_q, chunk[5], chunk[0], chunk[4:1]};
  assign wr_box    = cnt_q - 3'd1;

  always_comb begin
`ifdef SBOX_SEQ_OVERLAP_EN
    bus.in_ready = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
`else
    bus.in_ready = (state_q == StIdle);
`endif
    bus.out_valid = (state_q == StDone);
    bus.out_data  = out_q;
    busy          = (state_q != StIdle);
    accept        = bus.in_valid && bus.in_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = bus.in_data;
          cnt_d   = 3'd0;
          state_d = StLookup;
        end
      end
      StLookup: begin
        // The ROM returns box cnt-1 while box cnt is being addressed.
        if (cnt_q != 3'd0) begin
          out_d[~wr_box] = rom_q;
        end
        if (cnt_q == 3'd7) begin
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDrain: begin
        out_d[0] = rom_q;
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
`ifdef SBOX_SEQ_OVERLAP_EN
          if (accept) begin
            data_d  = bus.in_data;
            cnt_d   = 3'd0;
            state_d = StLookup;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      data_q  <= 48'h0;
      out_q   <= '0;
      rom_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      out_q   <= out_d;
      if (state_q == StLookup) begin
        // (63 - entry) * 4 selects the entry's nibble counted from the top.
        rom_q <= SboxRom[rom_addr[8:6]][{~rom_addr[5:0], 2'b00} +: 4];
      end
    end
  end

endmodule

// File: tb/tb_sbox_lookup_seq.sv
// Self-checking bench for sbox_lookup_seq against a table-driven DES S-box reference model.
module tb_sbox_lookup_seq;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   errors;

  sbox_lookup_seq_if bus ();

  sbox_lookup_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

`ifdef SBOX_SEQ_OVERLAP_EN
  localparam int ExpSpacing = 10;
`else
  localparam int ExpSpacing = 11;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIPS 46-3 S-boxes, 4 rows of 16 columns each.
  int sbox_tbl [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [31:0] sbox_ref(input logic [47:0] d);
    logic [31:0] r;
    int chunk, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      chunk = int'((d >> (42 - 6 * b)) & 48'h3F);
      row   = ((chunk >> 5) & 1) * 2 + (chunk & 1);
      col   = (chunk >> 1) & 15;
      r     = (r << 4) | 32'(sbox_tbl[b][row * 16 + col]);
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers d until accepted (bounded); returns just after the accepting edge.
  task automatic accept(input logic [47:0] d, output bit ok);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = rand48();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_fixed(input string name, input logic [47:0] d, input logic [31:0] want);
    bit ok;
    int lat;
    bus.out_ready = 1'b1;
    accept(d, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept got in_ready=0 want 1", name); end
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_busy got in_ready=%b busy=%b want 0/1", name, bus.in_ready, busy);
    end
    wait_out(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL %s_latency got %0d want 9", name, lat); end
    checks++; if (bus.out_data !== want) begin errors++; $display("FAIL %s_data got %h want %h", name, bus.out_data, want); end
    checks++; if (bus.out_data !== sbox_ref(d)) begin
      errors++; $display("FAIL %s_model got %h want %h", name, bus.out_data, sbox_ref(d));
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_release got out_valid=%b busy=%b want 0/0", name, bus.out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [47:0] d;
    logic [31:0] want;
    d    = rand48();
    want = sbox_ref(d);
    bus.out_ready = 1'b0;
    accept(d, ok);
    wait_out(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL bp_latency got %0d want 9", lat); end
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rand48();
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got out_valid=%b in_ready=%b want 1/0", i, bus.out_valid, bus.in_ready);
      end
      checks++; if (bus.out_data !== want) begin
        errors++; $display("FAIL bp_data_%0d got %h want %h", i, bus.out_data, want);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got out_valid=%b busy=%b in_ready=%b want 0/0/1",
                         bus.out_valid, busy, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.out_ready = 1'b1;
    accept(48'h0, ok);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_fixed("post_reset", 48'h0, 32'hEFA72C4D);
  endtask

  task automatic test_back_to_back();
    logic [47:0] ins [2];
    logic [31:0] outs [$];
    int acc [2];
    int idx, cyc;
    bit took;
    ins[0] = 48'h0;
    ins[1] = 48'hFFFF_FFFF_FFFF;
    acc    = '{0, 0};
    idx    = 0;
    cyc    = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = ins[0];
    while (outs.size() < 2 && cyc < 80) begin
      #1;
      took = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        acc[idx] = cyc;
        idx++;
        took = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) outs.push_back(bus.out_data);
      tick();
      cyc++;
      if (took) begin
        if (idx < 2) bus.in_data = ins[idx];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (outs.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", outs.size()); end
    checks++; if (outs[0] !== 32'hEFA72C4D) begin errors++; $display("FAIL b2b_first got %h want efa72c4d", outs[0]); end
    checks++; if (outs[1] !== 32'hD9CE3DCB) begin errors++; $display("FAIL b2b_second got %h want d9ce3dcb", outs[1]); end
    checks++; if (acc[1] - acc[0] !== ExpSpacing) begin
      errors++; $display("FAIL b2b_spacing got %0d want %0d", acc[1] - acc[0], ExpSpacing);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_q [$];
    logic [31:0] want;
    int n_sent, n_recv, cyc;
    bit took;
    n_sent = 0;
    n_recv = 0;
    cyc    = 0;
    bus.in_valid = 1'b0;
    while (n_recv < 1000 && cyc < 40000) begin
      if (!bus.in_valid && n_sent < 1000 && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1;
        bus.in_data  = rand48();
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      took = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(sbox_ref(bus.in_data));
        n_sent++;
        took = 1'b1;
      end
      if (bus.out_valid && bus.out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (bus.out_data !== want) begin
          errors++; $display("FAIL rand_%0d got %h want %h", n_recv, bus.out_data, want);
        end
        n_recv++;
      end
      tick();
      cyc++;
      if (took) bus.in_valid = 1'b0;
    end
    checks++; if (n_recv !== 1000 || exp_q.size() !== 0) begin
      errors++; $display("FAIL rand_count got %0d outputs (%0d pending) want 1000 (0)", n_recv, exp_q.size());
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 48'h0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_fixed("zeros", 48'h0, 32'hEFA72C4D);
    test_fixed("ones", 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
